sync_fifo_level: RTL and testbench



---
 rtl/sync_fifo_level.sv | 116 +++++++++++
 tb/tb_sync_fifo_level.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_level.sv
// sync_fifo_level: single-clock first-word-fall-through FIFO with a registered
// fill level, full/empty and almost-full/almost-empty status flags.
// Optional macro SYNC_FIFO_LEVEL_ERR_EN enables the sticky overflow/underflow
// flags; without it ovf_o/udf_o are constant 0 and no error logic exists.
module sync_fifo_level #(
    parameter int DATA_WIDTH          = 8,
    parameter int DATA_DEPTH          = 16,
    parameter int ALMOST_FULL_MARGIN  = 4,
    parameter int ALMOST_EMPTY_MARGIN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          full_o,
    output logic                          almost_full_o,
    output logic                          empty_o,
    output logic                          almost_empty_o,
    output logic [$clog2(DATA_DEPTH):0]   level_o,
    output logic                          ovf_o,
    output logic                          udf_o
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_L = PW'(DATA_DEPTH);
    localparam logic [PW-1:0] AF_TH   = PW'(DATA_DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [PW-1:0] AE_TH   = PW'(ALMOST_EMPTY_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level;
    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  rd_accept;

    // Status decode and handshake qualification from the registered level
    always_comb begin
        full      = (level == DEPTH_L);
        empty     = (level == '0);
        wr_accept = wr_valid_i && !full;
        rd_accept = rd_ready_i && !empty;
    end

    assign wr_ready_o     = !full;
    assign rd_valid_o     = !empty;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (level >= AF_TH);
    assign almost_empty_o = (level <= AE_TH);
    assign level_o        = level;
    assign rd_data_o      = mem[rd_ptr[AW-1:0]];

    // Storage write; memory is never reset, and a flushed write is dropped
    always_ff @(posedge clk) begin
        if (!rst && !clr_i && wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointers and level; reset beats flush, flush beats both handshakes
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_accept && !rd_accept) begin
                level <= level + PW'(1);
            end else if (rd_accept && !wr_accept) begin
                level <= level - PW'(1);
            end
        end
    end

`ifdef SYNC_FIFO_LEVEL_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags; a write attempt on full or a read attempt on empty sets them
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_valid_i && full) begin
                ovf_q <= 1'b1;
            end
            if (rd_ready_i && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// tb_sync_fifo_level: directed self-checking bench for sync_fifo_level with
// depth 8, almost-full margin 2 and almost-empty margin 1.
module tb_sync_fifo_level;

`ifdef SYNC_FIFO_LEVEL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        logic       clr;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        int         exp_level;
        logic [7:0] exp_data;
        bit         chk_data;
        bit         exp_ovf;
        bit         exp_udf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [7:0] wr_data_i;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic [7:0] rd_data_o;
    logic       full_o;
    logic       almost_full_o;
    logic       empty_o;
    logic       almost_empty_o;
    logic [3:0] level_o;
    logic       ovf_o;
    logic       udf_o;

    int checks = 0;
    int errors = 0;

    sync_fifo_level #(
        .DATA_WIDTH         (8),
        .DATA_DEPTH         (8),
        .ALMOST_FULL_MARGIN (2),
        .ALMOST_EMPTY_MARGIN(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_data_i     (wr_data_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_data_o     (rd_data_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .empty_o       (empty_o),
        .almost_empty_o(almost_empty_o),
        .level_o       (level_o),
        .ovf_o         (ovf_o),
        .udf_o         (udf_o)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every output against an expected level; flags follow depth 8, AF 6, AE 1
    task automatic check_state(input string tag, input int lvl, input logic [7:0] data,
                               input bit chk_data, input bit ovf, input bit udf);
        chk({tag, ".level"},        32'(level_o),        32'(lvl));
        chk({tag, ".full"},         32'(full_o),         32'(lvl == 8));
        chk({tag, ".almost_full"},  32'(almost_full_o),  32'(lvl >= 6));
        chk({tag, ".empty"},        32'(empty_o),        32'(lvl == 0));
        chk({tag, ".almost_empty"}, 32'(almost_empty_o), 32'(lvl <= 1));
        chk({tag, ".wr_ready"},     32'(wr_ready_o),     32'(lvl != 8));
        chk({tag, ".rd_valid"},     32'(rd_valid_o),     32'(lvl != 0));
        chk({tag, ".ovf"},          32'(ovf_o),          32'(ovf));
        chk({tag, ".udf"},          32'(udf_o),          32'(udf));
        if (chk_data) begin
            chk({tag, ".rd_data"}, 32'(rd_data_o), 32'(data));
        end
    endtask

    // One clock: inputs applied just after an edge, outputs sampled 1 after the next
    task automatic drive(input logic c, input logic w, input logic [7:0] d, input logic r);
        clr_i      = c;
        wr_valid_i = w;
        wr_data_i  = d;
        rd_ready_i = r;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic [7:0] d,
                                input logic r, input int lvl, input logic [7:0] data,
                                input bit chk_data, input bit ovf, input bit udf);
        vec_t v;
        v.clr = c; v.wr = w; v.wd = d; v.rd = r;
        v.exp_level = lvl; v.exp_data = data; v.chk_data = chk_data;
        v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    initial begin
        vec_t   vecs[$];
        logic [7:0] q[$];

        // Fill 0x11..0x18; head stays 0x11
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0, 1, 8'(8'h11 + i), 0, i + 1, 8'h11, 1, 0, 0));
        end
        // Full: write 0xAA with read -> 0x11 popped, 0xAA dropped
        vecs.push_back(mk(0, 1, 8'hAA, 1, 7, 8'h12, 1, ERR, 0));
        // Drain: heads 0x13..0x18, then empty
        for (int k = 1; k <= 6; k++) begin
            vecs.push_back(mk(0, 0, 8'h00, 1, 7 - k, 8'(8'h12 + k), 1, ERR, 0));
        end
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, ERR, 0));
        // Read on empty: no effect on level, underflow when enabled
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, ERR, ERR));
        // Flush clears sticky flags
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        // Fill to 5, then flush together with a write
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 1, 8'(8'h21 + i), 0, i + 1, 8'h21, 1, 0, 0));
        end
        vecs.push_back(mk(1, 1, 8'h26, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h30, 0, 1, 8'h30, 1, 0, 0));

        rst = 1'b1; clr_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 8'h00; rd_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 8'h00, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            check_state($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_data,
                        vecs[i].chk_data, vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Level 3 then 20 cycles of simultaneous read/write; pointers wrap past 16
        q = '{8'h30};
        drive(0, 1, 8'h31, 0); q.push_back(8'h31);
        drive(0, 1, 8'h32, 0); q.push_back(8'h32);
        check_state("lvl3", 3, q[0], 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 8'(8'h40 + i), 1);
            void'(q.pop_front());
            q.push_back(8'(8'h40 + i));
            check_state($sformatf("rw%0d", i), 3, q[0], 1, 0, 0);
        end

        // Level 4, then reset with a concurrent write and flush: reset wins
        drive(0, 1, 8'h60, 0);
        check_state("lvl4", 4, q[0], 1, 0, 0);
        rst = 1'b1;
        drive(1, 1, 8'h99, 1);
        rst = 1'b0;
        check_state("midrst", 0, 8'h00, 0, 0, 0);
        drive(0, 1, 8'h5C, 0);
        check_state("postrst", 1, 8'h5C, 1, 0, 0);
        drive(0, 0, 8'h00, 1);
        check_state("postrst_rd", 0, 8'h00, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
